// File: rtl/mha_pkg.sv
// Shared types and default dimensions for the multi-head attention blocks.
package mha_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned D_MODEL  = 192;
  localparam int unsigned N_TOKENS = 197;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ISSUE,
    WAIT
  } feeder_state_t;

endpackage

// File: rtl/mha_token_feeder.sv
// Packs a serial element stream into token rows and hands each row to the
// attention block with a one-cycle init pulse, waiting for its acknowledge.
module mha_token_feeder #(
  parameter  int unsigned DATA_W   = mha_pkg::DATA_W,
  parameter  int unsigned D_MODEL  = mha_pkg::D_MODEL,
  parameter  int unsigned N_TOKENS = mha_pkg::N_TOKENS,
  localparam int unsigned TOK_W    = (N_TOKENS > 1) ? $clog2(N_TOKENS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      s_valid,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      s_ready,
  output logic [DATA_W*D_MODEL-1:0] mha_block,
  output logic                      mha_init,
  input  logic                      mha_ready,
  output logic [TOK_W-1:0]          token_idx,
  output logic                      busy,
  output logic                      frame_done
);

  import mha_pkg::*;

  localparam int unsigned       ELEM_W    = (D_MODEL > 1) ? $clog2(D_MODEL) : 1;
  localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(D_MODEL - 1);
  localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(N_TOKENS - 1);

  feeder_state_t     state_q, state_d;
  logic [ELEM_W-1:0] elem_cnt;
  logic              accept;
  logic              last_elem;
  logic              ack;
  logic              last_tok;

  assign accept    = s_valid && (state_q == FILL);
  assign last_elem = (elem_cnt == ELEM_LAST);
  assign ack       = mha_ready && (state_q == WAIT);
  assign last_tok  = (token_idx == TOK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    s_ready  = 1'b0;
    mha_init = 1'b0;
    busy     = (state_q != IDLE);
    unique case (state_q)
      IDLE:  if (start) state_d = FILL;
      FILL: begin
        s_ready = 1'b1;
        if (accept && last_elem) state_d = ISSUE;
      end
      ISSUE: begin
        mha_init = 1'b1;
        state_d  = WAIT;
      end
      WAIT: if (ack) state_d = last_tok ? IDLE : FILL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elem_cnt   <= '0;
      token_idx  <= '0;
      mha_block  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= ack && last_tok;
      unique case (state_q)
        IDLE: if (start) begin
          elem_cnt  <= '0;
          token_idx <= '0;
        end
        FILL: if (accept) begin
          mha_block[elem_cnt*DATA_W +: DATA_W] <= s_data;
          elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
        end
        WAIT: if (ack) token_idx <= last_tok ? '0 : token_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mha_token_feeder.sv
// Randomized scoreboard bench for mha_token_feeder (D_MODEL=4, N_TOKENS=3).
module tb_mha_token_feeder;

  localparam int unsigned DW = 8;
  localparam int unsigned DM = 4;
  localparam int unsigned NT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          mha_ready = 1'b0;
  logic          s_ready;
  logic [DW*DM-1:0] mha_block;
  logic          mha_init;
  logic [1:0]    token_idx;
  logic          busy;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int tok      = 0;

  typedef struct {
    logic [31:0] row;
    int          idx;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] elems[DM];

  always #5 clk = ~clk;

  mha_token_feeder #(.DATA_W(DW), .D_MODEL(DM), .N_TOKENS(NT)) dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mha_block(mha_block), .mha_init(mha_init),
    .mha_ready(mha_ready), .token_idx(token_idx), .busy(busy), .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_block"}, mha_block, 32'h0);
    check({tag, "_idx"}, 32'(token_idx), 32'h0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'h0);
    check({tag, "_init"}, 32'(mha_init), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Scoreboard monitor: every mha_init pulse must match the next expected row.
  logic prev_init = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_init = 1'b0;
    end else begin
      if (mha_init) begin
        check("init_single_cycle", 32'(prev_init), 32'h0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL init_unexpected: mha_init with no pending token (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("row", mha_block, e.row);
          check("init_token_idx", 32'(token_idx), 32'(e.idx));
        end
      end
      prev_init = mha_init;
    end
  end

  task automatic rand_elems();
    for (int i = 0; i < DM; i++) elems[i] = 8'($urandom);
  endtask

  task automatic start_frame(input bit ready_in_fill);
    start = 1'b1;
    step();
    start = 1'b0;
    tok = 0;
    check("start_s_ready", 32'(s_ready), 32'h1);
    check("start_busy", 32'(busy), 32'h1);
    check("start_idx", 32'(token_idx), 32'h0);
    if (ready_in_fill) begin
      mha_ready = 1'b1;
      step();
      mha_ready = 1'b0;
      check("fill_ready_ignored_s_ready", 32'(s_ready), 32'h1);
      check("fill_ready_ignored_idx", 32'(token_idx), 32'h0);
    end
  endtask

  // Feeds the current elems[] as one token, then exercises ISSUE/WAIT.
  task automatic send_token(input int maxgap, input int bp, input bit ready_in_issue,
                            input bit start_in_wait);
    logic [31:0] row;
    int unsigned guard;
    row = '0;
    for (int i = 0; i < DM; i++) row = row + (32'(elems[i]) << (8 * i));
    for (int i = 0; i < DM; i++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        start   = 1'($urandom);
        step();
      end
      start   = 1'b0;
      s_valid = 1'b1;
      s_data  = elems[i];
      guard   = 0;
      while (!s_ready && guard < 50) begin
        step();
        guard++;
      end
      if (!s_ready) begin
        n_checks++;
        n_fail++;
        $display("FAIL s_ready_timeout: s_ready stayed 0, expected 1");
        s_valid = 1'b0;
        return;
      end
      if (i == DM - 1) exp_q.push_back('{row, tok});
      step();
    end
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    check("issue_init", 32'(mha_init), 32'h1);
    check("issue_s_ready", 32'(s_ready), 32'h0);
    if (ready_in_issue) mha_ready = 1'b1;
    step();
    mha_ready = 1'b0;
    check("wait_s_ready", 32'(s_ready), 32'h0);
    check("wait_idx", 32'(token_idx), 32'(tok));
    for (int c = 0; c < bp; c++) begin
      start = start_in_wait;
      s_valid = 1'($urandom);
      s_data  = 8'($urandom);
      step();
      check("bp_s_ready", 32'(s_ready), 32'h0);
      check("bp_block_stable", mha_block, row);
      check("bp_busy", 32'(busy), 32'h1);
    end
    start   = 1'b0;
    s_valid = 1'b0;
    mha_ready = 1'b1;
    step();
    mha_ready = 1'b0;
    if (tok == NT - 1) begin
      check("frame_done_pulse", 32'(frame_done), 32'h1);
      check("frame_done_busy", 32'(busy), 32'h0);
      check("frame_done_idx", 32'(token_idx), 32'h0);
      check("post_frame_block", mha_block, row);
      step();
      check("frame_done_once", 32'(frame_done), 32'h0);
      check("idle_s_ready", 32'(s_ready), 32'h0);
      tok = 0;
    end else begin
      check("ack_s_ready", 32'(s_ready), 32'h1);
      check("ack_no_frame_done", 32'(frame_done), 32'h0);
      check("ack_idx", 32'(token_idx), 32'(tok + 1));
      tok++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset asserted mid-cycle.
    #3 reset = 1'b1;
    #1 check_all_zero("reset_async");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_all_zero("reset_hold");
    end

    // Frame 1: fixed first token with long backpressure, then randomized tokens.
    start_frame(1'b0);
    elems[0] = 8'h11; elems[1] = 8'h22; elems[2] = 8'h33; elems[3] = 8'h44;
    send_token(0, 10, 1'b0, 1'b0);
    check("single_token_row", mha_block, 32'h44332211);
    rand_elems();
    send_token(3, 2, 1'b1, 1'b0);
    rand_elems();
    send_token(3, 3, 1'b0, 1'b1);

    // Frame 2: random gaps, spurious mha_ready in FILL and ISSUE.
    start_frame(1'b1);
    for (int t = 0; t < NT; t++) begin
      rand_elems();
      send_token(4, int'($urandom_range(4, 0)), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of filling a token.
    start_frame(1'b0);
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom_range(255, 1));
      step();
    end
    s_valid = 1'b0;
    #3 reset = 1'b1;
    #1 check_all_zero("reset_mid_fill");
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    check_all_zero("reset_mid_fill_release");

    // Frame 3: must restart from slot 0.
    start_frame(1'b0);
    for (int t = 0; t < NT; t++) begin
      rand_elems();
      send_token(3, int'($urandom_range(3, 0)), 1'($urandom), 1'b0);
    end

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
